// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: request front-end for a 256 x 16 single-port memory.
// Requests are queued in a small FIFO, issued in order to registered memory
// inputs, and read data comes back through a credit-limited response buffer.
// Optional feature macro: MEM_REQ_CTRL_WRITE_ACK_EN makes every write return a
// response beat carrying the written data, ordered with the reads.
module mem_req_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int RESP_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [7:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_rdata,
    output logic [7:0]  mem_address,
    output logic [15:0] mem_din,
    output logic        mem_wen,
    input  logic [15:0] mem_dout,
    output logic        busy
);

`ifdef MEM_REQ_CTRL_WRITE_ACK_EN
    localparam bit WRITE_ACK = 1'b1;
`else
    localparam bit WRITE_ACK = 1'b0;
`endif

    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int RIW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int RCW = $clog2(RESP_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, STALL, DRAIN} state_t;

    state_t r_state;
    state_t w_stateNext;

    logic            r_fifoWrite [FIFO_DEPTH];
    logic [7:0]      r_fifoAddr  [FIFO_DEPTH];
    logic [15:0]     r_fifoData  [FIFO_DEPTH];
    logic [FAW-1:0]  r_wrPtr;
    logic [FAW-1:0]  r_rdPtr;
    logic [FAW:0]    r_fifoCount;

    logic            r_s1Valid, r_s2Valid;
    logic            r_s1Ack, r_s2Ack;
    logic [15:0]     r_s1Data, r_s2Data;

    logic [15:0]     r_respMem [RESP_DEPTH];
    logic [RIW-1:0]  r_respWr;
    logic [RIW-1:0]  r_respRd;
    logic [RCW-1:0]  r_respCount;

    logic            w_accept, w_fifoEmpty, w_headWrite, w_hasCredit, w_issue;
    logic            w_inFlight, w_push, w_pop;
    logic [15:0]     w_pushData;
    logic [RCW:0]    w_used;

    assign w_fifoEmpty = (r_fifoCount == '0);
    assign req_ready   = (r_fifoCount != (FAW+1)'(FIFO_DEPTH));
    assign w_accept    = req_valid && req_ready;
    assign w_headWrite = r_fifoWrite[r_rdPtr];

    // Responses buffered plus beats still in the pipeline may never exceed the buffer size.
    assign w_used      = {1'b0, r_respCount} + (RCW+1)'(r_s1Valid) + (RCW+1)'(r_s2Valid);
    assign w_hasCredit = (w_used < (RCW+1)'(RESP_DEPTH));
    assign w_issue     = !w_fifoEmpty && ((w_headWrite && !WRITE_ACK) || w_hasCredit);
    assign w_inFlight  = r_s1Valid || r_s2Valid;

    assign w_push      = r_s2Valid;
    assign w_pushData  = r_s2Ack ? r_s2Data : mem_dout;
    assign resp_valid  = (r_respCount != '0);
    assign resp_rdata  = r_respMem[r_respRd];
    assign w_pop       = resp_valid && resp_ready;

    assign busy        = (r_state != IDLE) || resp_valid;

    // Request FIFO storage; contents need no reset because the count gates every read.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_fifoWrite[r_wrPtr] <= req_write;
            r_fifoAddr[r_wrPtr]  <= req_addr;
            r_fifoData[r_wrPtr]  <= req_wdata;
        end
    end

    // Request FIFO pointers and occupancy; accept and issue may happen together.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_fifoCount <= '0;
        end else begin
            if (w_accept) r_wrPtr <= r_wrPtr + FAW'(1);
            if (w_issue)  r_rdPtr <= r_rdPtr + FAW'(1);
            r_fifoCount <= r_fifoCount + (FAW+1)'(w_accept) - (FAW+1)'(w_issue);
        end
    end

    // Registered memory inputs: loaded on issue, write enable dropped otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_address <= '0;
            mem_din     <= '0;
            mem_wen     <= 1'b0;
        end else if (w_issue) begin
            mem_address <= r_fifoAddr[r_rdPtr];
            mem_din     <= w_headWrite ? r_fifoData[r_rdPtr] : 16'h0000;
            mem_wen     <= w_headWrite;
        end else begin
            mem_wen     <= 1'b0;
        end
    end

    // Two-stage tracker matching the memory's registered read path; write acks ride along.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1Valid <= 1'b0;
            r_s2Valid <= 1'b0;
            r_s1Ack   <= 1'b0;
            r_s2Ack   <= 1'b0;
            r_s1Data  <= '0;
            r_s2Data  <= '0;
        end else begin
            r_s1Valid <= w_issue && (!w_headWrite || WRITE_ACK);
            r_s1Ack   <= w_issue && w_headWrite;
            r_s1Data  <= r_fifoData[r_rdPtr];
            r_s2Valid <= r_s1Valid;
            r_s2Ack   <= r_s1Ack;
            r_s2Data  <= r_s1Data;
        end
    end

    // Response buffer; a pop frees its slot only from the following cycle onward.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_respWr    <= '0;
            r_respRd    <= '0;
            r_respCount <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) r_respMem[i] <= '0;
        end else begin
            if (w_push) begin
                r_respMem[r_respWr] <= w_pushData;
                r_respWr <= (r_respWr == RIW'(RESP_DEPTH - 1)) ? '0 : r_respWr + RIW'(1);
            end
            if (w_pop) begin
                r_respRd <= (r_respRd == RIW'(RESP_DEPTH - 1)) ? '0 : r_respRd + RIW'(1);
            end
            r_respCount <= r_respCount + RCW'(w_push) - RCW'(w_pop);
        end
    end

    // Controller state register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_stateNext;
    end

    // Next-state logic tracking whether the controller is issuing, stalled or draining.
    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            IDLE:  if (!w_fifoEmpty) w_stateNext = ISSUE;
            ISSUE: begin
                if (w_fifoEmpty)   w_stateNext = w_inFlight ? DRAIN : IDLE;
                else if (!w_issue) w_stateNext = STALL;
            end
            STALL: if (w_issue) w_stateNext = ISSUE;
            DRAIN: begin
                if (!w_fifoEmpty)     w_stateNext = ISSUE;
                else if (!w_inFlight) w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: scoreboard bench for mem_req_ctrl with a behavioural memory.
// Accepted requests are turned into expected responses using a shadow copy of
// memory contents; a separate monitor pops and compares every response beat.
module tb_mem_req_ctrl;

`ifdef MEM_REQ_CTRL_WRITE_ACK_EN
    localparam bit WRITE_ACK = 1'b1;
`else
    localparam bit WRITE_ACK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid, resp_ready;
    logic [15:0] resp_rdata;
    logic [7:0]  mem_address;
    logic [15:0] mem_din;
    logic        mem_wen;
    logic [15:0] mem_dout;
    logic        busy;

    int          assertCount = 0;
    int          failCount   = 0;
    int          monChecks   = 0;
    int          monFails    = 0;

    logic [15:0] memArr [256];
    logic [7:0]  memAddrQ = 8'h00;
    logic [15:0] shadow [256];
    logic [15:0] expQ [$];
    logic [15:0] expData;
    bit          randReady = 1'b0;
    logic [7:0]  wrapAddr [3] = '{8'hFE, 8'hFF, 8'h00};

    always #5 clock = ~clock;

    mem_req_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .mem_address (mem_address),
        .mem_din     (mem_din),
        .mem_wen     (mem_wen),
        .mem_dout    (mem_dout),
        .busy        (busy)
    );

    // Memory model: registered address and write, read data valid the cycle after.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) memArr[i] <= 16'h0100 + 16'(i);
        end else if (mem_wen) begin
            memArr[mem_address] <= mem_din;
        end
        memAddrQ <= mem_address;
    end
    assign mem_dout = memArr[memAddrQ];

    // Scoreboard monitor: predicts on request accept, compares on response handshake.
    always @(negedge clock) begin
        if (reset) begin
            expQ.delete();
            for (int i = 0; i < 256; i++) shadow[i] = 16'h0100 + 16'(i);
        end else begin
            if (resp_valid && resp_ready) begin
                monChecks++;
                if (expQ.size() == 0) begin
                    monFails++;
                    $display("[TB] FAIL resp_unexpected: got %h, expected no response", resp_rdata);
                end else begin
                    expData = expQ.pop_front();
                    if (resp_rdata !== expData) begin
                        monFails++;
                        $display("[TB] FAIL resp_data: got %h, expected %h", resp_rdata, expData);
                    end
                end
            end
            if (req_valid && req_ready) begin
                if (req_write) begin
                    shadow[req_addr] = req_wdata;
                    if (WRITE_ACK) expQ.push_back(req_wdata);
                end else begin
                    expQ.push_back(shadow[req_addr]);
                end
            end
        end
    end

    // Direct comparison of a sampled value against a bench-computed expectation.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge, optionally randomizing resp_ready.
    task automatic tick();
        @(posedge clock);
        #1;
        if (randReady) resp_ready = 1'($urandom_range(0, 1));
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic applyStimulus(input bit wr, input logic [7:0] a, input logic [15:0] d);
        int n = 0;
        bit acc = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        while (!acc && n < 300) begin
            @(negedge clock);
            acc = req_ready;
            tick();
            n++;
        end
        checkOutput("req_accept", 32'(acc), 32'd1);
        req_valid = 1'b0;
    endtask

    // Wait until every predicted response has been seen and the block is idle.
    task automatic waitIdle(input int budget);
        int n = 0;
        while ((expQ.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain_done", 32'(expQ.size() != 0 || busy), 32'd0);
    endtask

    initial begin
        int wenSeen;
        int holdBad;
        int n;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        repeat (3) tick();
        @(negedge clock);
        checkOutput("rst_req_ready",  32'(req_ready),   32'd1);
        checkOutput("rst_resp_valid", 32'(resp_valid),  32'd0);
        checkOutput("rst_resp_rdata", 32'(resp_rdata),  32'd0);
        checkOutput("rst_mem_addr",   32'(mem_address), 32'd0);
        checkOutput("rst_mem_din",    32'(mem_din),     32'd0);
        checkOutput("rst_mem_wen",    32'(mem_wen),     32'd0);
        checkOutput("rst_busy",       32'(busy),        32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Write then read the same address; response three edges after the read accept.
        resp_ready = 1'b1;
        applyStimulus(1'b1, 8'h12, 16'hBEEF);
        applyStimulus(1'b0, 8'h12, 16'h0000);
        wenSeen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (mem_wen) wenSeen++;
            if (i == 2) checkOutput("resp_early", 32'(resp_valid), 32'(WRITE_ACK));
            if (i == 3) begin
                checkOutput("resp_latency", 32'(resp_valid), 32'd1);
                checkOutput("rd_data",      32'(resp_rdata), 32'hBEEF);
            end
        end
        checkOutput("wen_pulse", 32'(wenSeen), 32'd1);
        tick();
        waitIdle(200);

        // Backpressure: six reads with the response side stalled.
        resp_ready = 1'b0;
        for (int a = 0; a < 6; a++) applyStimulus(1'b0, 8'(a), 16'h0000);
        holdBad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (!resp_valid || resp_rdata !== 16'h0100) holdBad++;
            if (i == 9) begin
                checkOutput("bp_fifo_full", 32'(req_ready), 32'd0);
                checkOutput("bp_busy",      32'(busy),      32'd1);
            end
            tick();
        end
        checkOutput("bp_hold", 32'(holdBad), 32'd0);
        resp_ready = 1'b1;
        waitIdle(200);

        // Full FIFO: head read without credit, extra request must be refused.
        resp_ready = 1'b0;
        for (int a = 0; a < 6; a++) applyStimulus(1'b0, 8'h20 + 8'(a), 16'h0000);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h26;
        @(negedge clock);
        checkOutput("full_ready_low", 32'(req_ready), 32'd0);
        tick();
        resp_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!req_ready && n < 20);
        checkOutput("full_ready_return", 32'(n), 32'd3);
        tick();
        req_valid = 1'b0;
        waitIdle(200);

        // Reset with reads queued, one in flight and one buffered.
        resp_ready = 1'b0;
        for (int a = 0; a < 4; a++) applyStimulus(1'b0, 8'h30 + 8'(a), 16'h0000);
        reset = 1'b1;
        tick();
        @(negedge clock);
        checkOutput("mid_rst_req_ready",  32'(req_ready),  32'd1);
        checkOutput("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("mid_rst_busy",       32'(busy),       32'd0);
        checkOutput("mid_rst_rdata",      32'(resp_rdata), 32'd0);
        tick();
        reset      = 1'b0;
        resp_ready = 1'b1;
        repeat (12) tick();
        checkOutput("post_rst_idle", 32'(busy), 32'd0);

        // Alternating write/read pairs over the top and bottom of the address space.
        randReady = 1'b1;
        for (int k = 0; k < 20; k++) begin
            logic [15:0] d;
            d = 16'($urandom);
            applyStimulus(1'b1, wrapAddr[k % 3], d);
            applyStimulus(1'b0, wrapAddr[k % 3], 16'h0000);
        end
        randReady  = 1'b0;
        resp_ready = 1'b1;
        waitIdle(300);

        // Write then read of the same word; with write acks both beats carry the data.
        applyStimulus(1'b1, 8'h05, 16'h1234);
        applyStimulus(1'b0, 8'h05, 16'h0000);
        waitIdle(200);

        // Random traffic with random response backpressure.
        randReady = 1'b1;
        for (int k = 0; k < 60; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 7)), 16'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end
        randReady  = 1'b0;
        resp_ready = 1'b1;
        waitIdle(500);

        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("final_busy",        32'(busy),         32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount + monChecks, failCount + monFails);
        $finish;
    end

endmodule
